// File: rtl/posit8_encode_pipe.sv
// Purpose: encode sign/regime/fraction fields into an 8-bit posit (es=0) with round-to-nearest-even.
// Latency: 2 cycles (S1 body/guard/sticky, S2 rounded signed result), 1 transfer per cycle.
// Backpressure: valid/ready; in_ready = !s1_valid | !s2_valid | out_ready; bubbles collapse into an empty S2.
module posit8_encode_pipe #(
    parameter int N  = 8,
    parameter int ES = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sign,
    input  logic [4:0]   in_k,
    input  logic [N-1:0] in_frac,
    input  logic         in_zero,
    input  logic         in_nar,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_posit
);

    // Only the 8-bit, es=0 format is implemented.
    if (N != 8 || ES != 0) begin : g_bad_param
        $error("posit8_encode_pipe supports only N=8, ES=0");
    end

    // Pipeline valid bits and stage-advance enables.
    logic s1_valid_q, s2_valid_q;
    logic s2_adv, s1_adv;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;

    // ---------------- Stage 1: regime + fraction bit string ----------------
    logic signed [4:0] k_s;
    logic              sat_hi, sat_lo;
    logic [4:0]        rlen;
    logic [4:0]        shamt;
    logic [23:0]       regime_w;
    logic [23:0]       word_w;
    logic [6:0]        s1_body_d;
    logic              s1_guard_d, s1_sticky_d;

    assign k_s    = $signed(in_k);
    assign sat_hi = (k_s >= 5'sd6);
    assign sat_lo = (k_s <= -5'sd7);

    // Lay the regime MSB-first into a 24-bit window, then append the fraction right after it.
    always_comb begin
        shamt    = 5'd0;
        rlen     = 5'd0;
        regime_w = 24'h0;
        if (!k_s[4]) begin
            // k >= 0: (k+1) ones, the terminating zero is implicit below them.
            shamt    = in_k + 5'd1;
            rlen     = in_k + 5'd2;
            regime_w = ~(24'hFF_FFFF >> shamt);
        end else begin
            // k < 0: (-k) zeros then a single one.
            shamt    = 5'd0 - in_k;
            rlen     = shamt + 5'd1;
            regime_w = 24'h80_0000 >> shamt;
        end
        word_w = regime_w | ({in_frac, 16'h0000} >> rlen);

        s1_body_d   = word_w[23:17];
        s1_guard_d  = word_w[16];
        s1_sticky_d = |word_w[15:0];
        // Out-of-range regimes pin to maxpos / minpos with nothing left to round.
        if (sat_hi) begin
            s1_body_d   = 7'h7F;
            s1_guard_d  = 1'b0;
            s1_sticky_d = 1'b0;
        end else if (sat_lo) begin
            s1_body_d   = 7'h01;
            s1_guard_d  = 1'b0;
            s1_sticky_d = 1'b0;
        end
    end

    logic       s1_sign_q, s1_zero_q, s1_nar_q;
    logic [6:0] s1_body_q;
    logic       s1_guard_q, s1_sticky_q;

    // S1 payload capture on an accepted input; no reset needed since s1_valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (rst_n && s1_adv && in_valid) begin
            s1_sign_q   <= in_sign;
            s1_zero_q   <= in_zero;
            s1_nar_q    <= in_nar;
            s1_body_q   <= s1_body_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
        end
    end

    // ---------------- Stage 2: round, clamp, apply sign ----------------
    logic       round_inc;
    logic [6:0] body_rnd;
    logic [7:0] mag;
    logic [7:0] out_posit_d;

    // RNE increment; a body already at maxpos stays there so rounding never yields NaR.
    always_comb begin
        round_inc   = s1_guard_q && (s1_body_q[0] || s1_sticky_q);
        body_rnd    = (s1_body_q == 7'h7F) ? 7'h7F : s1_body_q + {6'd0, round_inc};
        mag         = {1'b0, body_rnd};
        out_posit_d = s1_sign_q ? (~mag + 8'd1) : mag;
        if (s1_zero_q) begin
            out_posit_d = 8'h00;
        end else if (s1_nar_q) begin
            out_posit_d = 8'h80;
        end
    end

    logic [7:0] out_posit_q;
    assign out_posit = out_posit_q;

    // Valid bits and result register; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_posit_q <= 8'h00;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_posit_q <= out_posit_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit8_encode_pipe.sv
// Purpose: self-checking bench for posit8_encode_pipe against a bit-list reference model.
// Latency: checks the 2-cycle pipeline latency and 1/cycle throughput.
// Backpressure: exercises output stalls, bubble collapse and mid-stream reset.
module tb_posit8_encode_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic [4:0] in_k;
    logic [7:0] in_frac;
    logic       in_zero;
    logic       in_nar;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_posit;

    posit8_encode_pipe #(.N(8), .ES(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_k      (in_k),
        .in_frac   (in_frac),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_out = 0;
    int cur_lit = -1;
    bit check_lat = 1'b0;

    logic [7:0] exp_q[$];
    int         lit_q[$];
    int         acc_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: spell out the bit string, cut the body, round on the leftover bits.
    function automatic logic [7:0] model(input bit s, input int k, input logic [7:0] f,
                                         input bit z, input bit n);
        bit bits[$];
        int body;
        bit g;
        bit st;
        g  = 1'b0;
        st = 1'b0;
        if (z) return 8'h00;
        if (n) return 8'h80;
        if (k >= 6) begin
            body = 127;
        end else if (k <= -7) begin
            body = 1;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                repeat (-k) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            for (int i = 7; i >= 0; i--) bits.push_back(f[i]);
            body = 0;
            for (int i = 0; i < 7; i++) body = body * 2 + int'(bits[i]);
            g = bits[7];
            for (int i = 8; i < bits.size(); i++) st = st | bits[i];
            if (g && ((body % 2) == 1 || st)) body++;
            if (body > 127) body = 127;
        end
        return s ? 8'((256 - body) % 256) : 8'(body);
    endfunction

    // Monitor/scoreboard: samples on the falling edge, between active edges.
    logic [7:0] held = 8'h00;
    bit         stall = 1'b0;
    always @(negedge clk) begin
        logic [7:0] e;
        int l;
        int a;
        if (!rst_n) begin
            exp_q.delete();
            lit_q.delete();
            acc_q.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_posit", int'(out_posit), int'(held));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", int'(out_posit), -1);
                end else begin
                    e = exp_q.pop_front();
                    l = lit_q.pop_front();
                    a = acc_q.pop_front();
                    chk("posit_vs_model", int'(out_posit), int'(e));
                    if (l >= 0) chk("posit_vs_literal", int'(out_posit), l);
                    if (check_lat) chk("latency", cyc - a, 2);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_sign, int'($signed(in_k)), in_frac, in_zero, in_nar));
                lit_q.push_back(cur_lit);
                acc_q.push_back(cyc);
            end
            stall = out_valid && !out_ready;
            held  = out_posit;
        end
    end

    // Present one input and hold it until accepted; called just after a rising edge.
    task automatic send(input bit s, input int k, input logic [7:0] f, input bit z,
                        input bit n, input int lit);
        bit acc;
        in_valid = 1'b1;
        in_sign  = s;
        in_k     = k[4:0];
        in_frac  = f;
        in_zero  = z;
        in_nar   = n;
        cur_lit  = lit;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        @(posedge clk);
        #1;
        chk("drained", exp_q.size(), 0);
    endtask

    typedef struct {
        bit         s;
        int         k;
        logic [7:0] f;
        bit         z;
        bit         n;
        int         exp;
    } vec_t;

    vec_t vt[20] = '{
        '{1'b0,   0, 8'h00, 1'b0, 1'b0, 'h40},
        '{1'b0,  -1, 8'h00, 1'b0, 1'b0, 'h20},
        '{1'b1,   0, 8'h00, 1'b0, 1'b0, 'hC0},
        '{1'b0,   0, 8'h80, 1'b0, 1'b0, 'h50},
        '{1'b0,   5, 8'h80, 1'b0, 1'b0, 'h7E},
        '{1'b0,   5, 8'h81, 1'b0, 1'b0, 'h7F},
        '{1'b0,   0, 8'h0C, 1'b0, 1'b0, 'h42},
        '{1'b0,   6, 8'h00, 1'b0, 1'b0, 'h7F},
        '{1'b0,   9, 8'h00, 1'b0, 1'b0, 'h7F},
        '{1'b0,  -9, 8'h00, 1'b0, 1'b0, 'h01},
        '{1'b1,  -9, 8'h00, 1'b0, 1'b0, 'hFF},
        '{1'b1,   3, 8'h5A, 1'b1, 1'b0, 'h00},
        '{1'b1,  -2, 8'h33, 1'b0, 1'b1, 'h80},
        '{1'b0,   0, 8'h00, 1'b1, 1'b1, 'h00},
        '{1'b0,  -6, 8'h80, 1'b0, 1'b0, 'h02},
        '{1'b0,  15, 8'hFF, 1'b0, 1'b0, 'h7F},
        '{1'b0, -16, 8'hFF, 1'b0, 1'b0, 'h01},
        '{1'b1,   5, 8'h81, 1'b0, 1'b0, 'h81},
        '{1'b0,   2, 8'hFF, 1'b0, 1'b0, 'h78},
        '{1'b1,  -1, 8'h40, 1'b0, 1'b0, 'hD8}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int o0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_k      = 5'd0;
        in_frac   = 8'h00;
        in_zero   = 1'b0;
        in_nar    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_posit", int'(out_posit), 0);
        rst_n = 1'b1;

        // Directed encodes with hand-computed results.
        out_ready = 1'b1;
        foreach (vt[i]) begin
            chk("model_pin", int'(model(vt[i].s, vt[i].k, vt[i].f, vt[i].z, vt[i].n)), vt[i].exp);
            send(vt[i].s, vt[i].k, vt[i].f, vt[i].z, vt[i].n, vt[i].exp);
        end
        drain();

        // Throughput: 16 back-to-back, each must emerge exactly 2 cycles after acceptance.
        check_lat = 1'b1;
        c0 = cyc;
        o0 = n_out;
        for (int i = 0; i < 16; i++) begin
            send(i[0], i - 8, 8'(i * 17), 1'b0, 1'b0, -1);
        end
        chk("tput_accept_cycles", cyc - c0, 16);
        drain();
        check_lat = 1'b0;
        chk("tput_outputs", n_out - o0, 16);

        // Backpressure: two inputs fill both stages, then in_ready must drop.
        o0 = n_out;
        out_ready = 1'b0;
        send(1'b0, 1, 8'h10, 1'b0, 1'b0, 'h61);
        send(1'b1, 0, 8'h00, 1'b0, 1'b0, 'hC0);
        @(negedge clk);
        chk("bp_in_ready_low", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b0, -2, 8'hC0, 1'b0, 1'b0, 'h1C);
        send(1'b0, 3, 8'h00, 1'b0, 1'b0, 'h78);
        drain();
        chk("bp_outputs", n_out - o0, 4);

        // Reset with both stages full; an input offered during reset must not be taken.
        out_ready = 1'b0;
        send(1'b0, 0, 8'h00, 1'b0, 1'b0, -1);
        send(1'b0, 1, 8'h00, 1'b0, 1'b0, -1);
        o0 = n_out;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_k      = 5'd2;
        cur_lit   = -1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_in_ready", int'(in_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_no_stale", n_out - o0, 0);

        // Recovery after reset.
        send(1'b0, 0, 8'h00, 1'b0, 1'b0, 'h40);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/posit8_encode_pipe.md
POSIT8_ENCODE_PIPE -- requirements
Module: posit8_encode_pipe

Interface
REQ-001 SHALL have parameter N, default 8, posit width; only 8 is supported.
REQ-002 SHALL have parameter ES, default 0, exponent width; only 0 is supported.
REQ-003 SHALL have port clk input 1: single clock, rising edge.
REQ-004 SHALL have port rst_n input 1: synchronous active-low reset, sampled on clk.
REQ-005 SHALL have port in_valid input 1: input fields valid.
REQ-006 SHALL have port in_ready output 1: block accepts input this cycle.
REQ-007 SHALL have port in_sign input 1: 1 = negative.
REQ-008 SHALL have port in_k input 5: signed regime value, range -16..15.
REQ-009 SHALL have port in_frac input 8: fraction bits after hidden 1, MSB-aligned.
REQ-010 SHALL have port in_zero input 1: encode zero; overrides all other fields.
REQ-011 SHALL have port in_nar input 1: encode NaR; overrides all but in_zero.
REQ-012 SHALL have port out_valid output 1: out_posit valid.
REQ-013 SHALL have port out_ready input 1: downstream accepts.
REQ-014 SHALL have port out_posit output 8: encoded posit.

Function
REQ-015 SHALL accept a transfer on in_valid & in_ready and emit one on out_valid & out_ready, in order, with no loss or duplication.
REQ-016 SHALL be a 2-stage pipeline: S1 registers regime/fraction body plus guard and sticky; S2 registers the rounded, signed result.
REQ-017 SHALL produce out_valid 2 cycles after acceptance when out_ready is held high, at full throughput of 1 per cycle.
REQ-018 SHALL drive in_ready = !s1_valid | !s2_valid | out_ready, combinationally with no dependency on in_valid.
REQ-019 SHALL hold out_posit and out_valid stable while out_valid & !out_ready.
REQ-020 SHALL collapse bubbles: S1 SHALL advance into an empty S2 even when out_ready is low.
REQ-021 SHALL encode the regime as follows.
- k >= 0: (k+1) ones then a zero.
- k < 0: (-k) zeros then a one.
REQ-022 SHALL build the 7-bit body as regime MSB-first followed by in_frac MSB-first, truncated to 7 bits.
REQ-023 SHALL take guard as the first bit past the body, and sticky as the OR of all remaining bits.
REQ-024 SHALL round to nearest, ties to even: increment the body iff guard & (body[0] | sticky).
REQ-025 SHALL saturate: k >= 6 gives body 0x7F; k <= -7 gives body 0x01.
REQ-026 SHALL clamp a rounding increment from 0x7F to 0x7F, so the result never becomes NaR.
REQ-027 SHALL never produce zero from a nonzero input.
REQ-028 SHALL output {0,body} when the sign is positive and the 8-bit two's complement of {0,body} when negative.
REQ-029 SHALL output 0x00 for in_zero and 0x80 for in_nar, regardless of sign, k and frac.
REQ-030 SHALL ignore input fields when in_valid is low.

Reset
REQ-031 SHALL, with rst_n low at a clk edge, clear s1_valid, s2_valid and out_posit to 0, so out_valid is 0 and in_ready is 1 the next cycle.
REQ-032 SHALL discard in-flight data on reset mid-operation; no output SHALL follow for transfers accepted before reset.
REQ-033 SHALL NOT accept a transfer in a cycle where rst_n is low.

Verification
REQ-034 SHALL cover basic encodes:
- k=0, frac=0x00, sign=0 -> 0x40.
- k=-1 -> 0x20.
- k=0, sign=1 -> 0xC0.
- k=0, frac=0x80 -> 0x50.
REQ-035 SHALL cover rounding:
- k=5, frac=0x80 (tie, body LSB 0) -> 0x7E.
- k=5, frac=0x81 -> 0x7F.
- k=0, frac=0x0C -> 0x42.
REQ-036 SHALL cover saturation and specials:
- k=6 or k=9 -> 0x7F.
- k=-9 -> 0x01.
- k=-9, sign=1 -> 0xFF.
- in_zero -> 0x00.
- in_nar -> 0x80.
REQ-037 SHALL cover backpressure: stream 4 inputs with out_ready low for cycles 2-5 -> in_ready falls after 2 held, then all 4 emerge in order with no duplicates once out_ready rises.
REQ-038 SHALL cover reset mid-stream: rst_n low for 1 cycle with both stages full -> out_valid=0 and in_ready=1 next cycle, and no stale output.
REQ-039 SHALL cover throughput: 16 back-to-back inputs with out_ready high -> 16 outputs on consecutive cycles starting 2 cycles after the first input.
